muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative HI/LO multiply/divide unit for the five-stage MIPS pipeline. It sits beside the EXE-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EXE. It holds the architectural HI and LO registers. While an operation is in flight it raises a stall request that the pipeline hazard unit ORs into `stall_fetch`/`stall_decode`/`clear_exe`, so a later HI/LO-touching instruction waits in decode.

## Interface
Parameters:
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_exe` in 1: EXE holds a valid muldiv-class instruction.
- `md_op_exe` in 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 11x is a no-op.
- `srca_exe` in WIDTH: forwarded rs value.
- `srcb_exe` in WIDTH: forwarded rt value.
- `md_req_decode` in 1: decode holds MFHI/MFLO/MTHI/MTLO/MULT(U)/DIV(U).
- `busy` out 1: a multi-cycle operation is in flight.
- `stall_md` out 1: stall request to the hazard unit.
- `hi` out WIDTH: architectural HI register.
- `lo` out WIDTH: architectural LO register.

## Operation
- **States:** IDLE, RUN, FIX.
- **Acceptance:** an op is accepted at a rising edge when `start_exe`=1 and state=IDLE. In any other state, `start_exe` is ignored; the hazard unit guarantees this never happens for valid code.
- **MTHI/MTLO:** write `srca_exe` into `hi` or `lo` at the accepting edge. State stays IDLE.
- **MULT(U)/DIV(U) on acceptance:**
  - Latch operand magnitudes. For signed ops, take the absolute value; for unsigned ops, use the raw value.
  - Latch the sign flags.
  - Load `count`=WIDTH-1 and go to RUN.
- **RUN, multiply:** one shift-add step per cycle on a 2·WIDTH accumulator.
- **RUN, divide:** one restoring step per cycle. Shift the remainder left with the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- **RUN exit:** `count` decrements each cycle; at `count`=0, go to FIX.
- **FIX:** apply sign correction, then write HI/LO at the edge leaving FIX; state returns to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient sign = XOR of the operand signs; remainder sign = dividend sign.
  - Mult: `hi`/`lo` = product[2W-1:W] / product[W-1:0].
  - Div: `lo` = quotient, `hi` = remainder.
- **Divide by zero:** `lo` = all ones, `hi` = dividend (raw, unsigned view). Still takes the full latency.
- **Signed overflow** (−2^(W−1) / −1): `lo` = 0x80000000, `hi` = 0. This falls out of the magnitude arithmetic with no special-casing.
- **Outputs:** `busy` = (state≠IDLE). `stall_md` = `md_req_decode` & (`busy` | (`start_exe` & IDLE & op∈{MULT,MULTU,DIV,DIVU})).
- **Reset:** asserting `rst` at any time, including mid-RUN, sends state to IDLE and clears `hi`=`lo`=0, `count`=0, `busy`=0 at that edge.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `stall_md`=0 (given `md_req_decode`=0).
- **Latency:** accept at edge E0; RUN occupies cycles E0..E0+WIDTH; FIX is one cycle; HI/LO are valid after edge E0+WIDTH+1, i.e. 33 edges for WIDTH=32.
- **Busy window:** `busy` is high for exactly WIDTH+1 cycles.
- **MTHI/MTLO:** HI/LO are updated after the accepting edge; zero stall.
- **Combinational stall:** `stall_md` is combinational so that a muldiv-class instruction in decode stalls in the same cycle its predecessor is accepted. It deasserts in the FIX cycle's successor, so MFHI in decode reads the updated HI at the next edge.
- **Outputs:** `hi`/`lo` are registered outputs with no read bypass; MFHI/MFLO are held in decode until `busy`=0.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:**
  - MULT/MULTU compute the full product combinationally and write HI/LO at the accepting edge.
  - No RUN/FIX entry, `busy` stays 0, and the multiply term is removed from `stall_md`.
  - DIV/DIVU are unchanged.
- **`MULDIV_FAST_MUL_EN` undefined:** the iterative WIDTH+1-cycle multiply described above.

## Test plan
- **Reset:** assert `rst` 1 cycle → `hi`=`lo`=0, `busy`=0.
- **MULT:** signed, `srca`=0xFFFFFFFD (−3), `srcb`=7 → after 33 edges `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high exactly 33 cycles.
- **DIV:** signed, −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/0 → `lo`=0xFFFFFFFF, `hi`=7.
- **Stall handshake:** DIVU accepted with MFLO in decode → `stall_md`=1 from the accept cycle through the FIX cycle, 0 afterwards; `lo` is stable at the quotient when the stall drops.
- **Reset mid-RUN:** `rst` at cycle 10 of a MULT → state IDLE, `hi`=`lo`=0; a new MTLO 0x1234 then writes `lo`=0x1234 after one edge.
- **With `MULDIV_FAST_MUL_EN`:** MULTU 0xFFFFFFFF × 2 → `hi`=1, `lo`=0xFFFFFFFE one edge after accept; `busy` never asserts.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit (iterative shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to make MULT/MULTU single-cycle; DIV/DIVU stay iterative.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_exe,
    input  logic [2:0]       md_op_exe,
    input  logic [WIDTH-1:0] srca_exe,
    input  logic [WIDTH-1:0] srcb_exe,
    input  logic             md_req_decode,
    output logic             busy,
    output logic             stall_md,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_count;
    // Multiply: {partial product, multiplier}.  Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_zero;

    logic               w_op_mul;
    logic               w_op_div;
    logic               w_op_mthi;
    logic               w_op_mtlo;
    logic               w_op_iter;
    logic               w_signed;
    logic               w_idle;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot_mag;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_op_mul  = (md_op_exe[2:1] == 2'b00);
    assign w_op_div  = (md_op_exe[2:1] == 2'b01);
    assign w_op_mthi = (md_op_exe == 3'b100);
    assign w_op_mtlo = (md_op_exe == 3'b101);
    assign w_signed  = ~md_op_exe[0];
    assign w_idle    = (r_state == S_IDLE);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_fast_prod;

    // A truncated 2W x 2W product of sign-extended operands is the exact signed product.
    assign w_ext_a     = {{WIDTH{w_neg_a}}, srca_exe};
    assign w_ext_b     = {{WIDTH{w_neg_b}}, srcb_exe};
    assign w_fast_prod = w_ext_a * w_ext_b;
    assign w_op_iter   = w_op_div;
`else
    assign w_op_iter   = w_op_mul | w_op_div;
`endif

    assign w_neg_a = w_signed & srca_exe[WIDTH-1];
    assign w_neg_b = w_signed & srcb_exe[WIDTH-1];
    assign w_mag_a = w_neg_a ? -srca_exe : srca_exe;
    assign w_mag_b = w_neg_b ? -srcb_exe : srcb_exe;

    // One iteration step; bit WIDTH of the trial difference is its borrow (negative result).
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_div_trial[WIDTH]) begin
                w_acc_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_step = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_prod     = r_neg_res ? -r_acc : r_acc;
    assign w_quot_mag = r_acc[WIDTH-1:0];
    assign w_rem_mag  = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot     = r_neg_res ? -w_quot_mag : w_quot_mag;
    assign w_rem      = r_neg_rem ? -w_rem_mag : w_rem_mag;

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_fix_hi = r_dividend;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quot;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_exe && w_op_iter) w_state_next = S_RUN;
            S_RUN:   if (r_count == '0) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_exe) begin
                        if (w_op_mthi) r_hi <= srca_exe;
                        if (w_op_mtlo) r_lo <= srca_exe;
`ifdef MULDIV_FAST_MUL_EN
                        if (w_op_mul) begin
                            r_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_fast_prod[WIDTH-1:0];
                        end
`endif
                        if (w_op_iter) begin
                            r_count    <= CW'(WIDTH - 1);
                            r_is_div   <= w_op_div;
                            r_neg_res  <= w_neg_a ^ w_neg_b;
                            r_neg_rem  <= w_neg_a;
                            r_div_zero <= (srcb_exe == '0);
                            r_dividend <= srca_exe;
                            if (w_op_div) begin
                                r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                                r_opnd <= w_mag_b;
                            end else begin
                                r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                                r_opnd <= w_mag_a;
                            end
                        end
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_step;
                    r_count <= r_count - 1'b1;
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    // Combinational so a dependent instruction in decode stalls in its predecessor's accept cycle.
    assign busy     = ~w_idle;
    assign stall_md = md_req_decode & (busy | (start_exe & w_idle & w_op_iter));
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected HI/LO and busy length, monitor checks.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit MUL_ITER = 1'b0;
`else
    localparam bit MUL_ITER = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start_exe;
    logic [2:0]   md_op_exe;
    logic [W-1:0] srca_exe;
    logic [W-1:0] srcb_exe;
    logic         md_req_decode;
    logic         busy;
    logic         stall_md;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cycles;
        int           id;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   next_id = 0;
    logic strobe  = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_exe    (start_exe),
        .md_op_exe    (md_op_exe),
        .srca_exe     (srca_exe),
        .srcb_exe     (srcb_exe),
        .md_req_decode(md_req_decode),
        .busy         (busy),
        .stall_md     (stall_md),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input bit iter);
        exp_t e;
        e.hi     = e_hi;
        e.lo     = e_lo;
        e.cycles = iter ? W + 1 : 0;
        e.id     = next_id;
        next_id++;
        sb_q.push_back(e);
    endtask

    // Present one op for one accepting edge, then wait for its result to be presented.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input bit iter);
        bit done;
        push_exp(e_hi, e_lo, iter);
        start_exe = 1'b1;
        md_op_exe = op;
        srca_exe  = a;
        srcb_exe  = b;
        #1;
        check($sformatf("stall_at_accept%0d", next_id - 1), 64'(stall_md), 64'(md_req_decode & iter));
        @(posedge clk);
        #1 start_exe = 1'b0;
        if (iter) begin
            done = 1'b0;
            for (int t = 0; t < 4 * W; t++) begin
                @(negedge clk);
                if (busy === 1'b0) begin
                    done = 1'b1;
                    break;
                end
            end
            check("busy_timeout", 64'(done), 64'd1);
        end else begin
            strobe = 1'b1;
            @(posedge clk);
            #1 strobe = 1'b0;
        end
    endtask

    // Monitor: a result is presented when busy falls, or one cycle after a zero-latency op.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                busy_cnt = 0;
            end else if (busy === 1'b1) begin
                busy_cnt++;
            end else if (busy_cnt > 0 || strobe) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 64'(busy_cnt), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("res%0d_hi", e.id), 64'(hi), 64'(e.hi));
                    check($sformatf("res%0d_lo", e.id), 64'(lo), 64'(e.lo));
                    check($sformatf("res%0d_busy_cycles", e.id), 64'(busy_cnt), 64'(e.cycles));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        rst           = 1'b1;
        start_exe     = 1'b0;
        md_op_exe     = 3'b000;
        srca_exe      = '0;
        srcb_exe      = '0;
        md_req_decode = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall", 64'(stall_md), 64'd0);

        // Multiply: signed/unsigned, sign-corrected and extreme operands.
        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_ITER);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MUL_ITER);
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_ITER);
        issue(OP_MULT,  32'd100,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF9C, MUL_ITER);

        // Divide: sign rules, divide by zero, signed overflow.
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1);
        issue(OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);
        issue(OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 1'b1);

        // Moves never stall, even with a HI/LO consumer in decode; the no-op changes nothing.
        md_req_decode = 1'b1;
        issue(OP_MTHI,  32'hCAFE_BABE, 32'd0,         32'hCAFE_BABE, 32'h0FFF_FFFF, 1'b0);
        md_req_decode = 1'b0;
        issue(OP_MTLO,  32'h0BAD_F00D, 32'd9,         32'hCAFE_BABE, 32'h0BAD_F00D, 1'b0);
        issue(OP_NOP,   32'd5,         32'd5,         32'hCAFE_BABE, 32'h0BAD_F00D, 1'b0);

        // Stall handshake: DIVU with MFLO waiting in decode.
        push_exp(32'd2, 32'd14, 1'b1);
        md_req_decode = 1'b1;
        start_exe     = 1'b1;
        md_op_exe     = OP_DIVU;
        srca_exe      = 32'd100;
        srcb_exe      = 32'd7;
        #1 check("hs_stall_accept", 64'(stall_md), 64'd1);
        @(posedge clk);
        #1 start_exe = 1'b0;
        held = 0;
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            if (stall_md === 1'b1 && busy === 1'b1) held++;
        end
        check("hs_stall_held_cycles", 64'(held), 64'(W + 1));
        @(negedge clk);
        check("hs_stall_drop", 64'(stall_md), 64'd0);
        check("hs_lo_at_drop", 64'(lo), 64'd14);
        md_req_decode = 1'b0;

        // Reset in the middle of an iterative op, then a move.
        @(posedge clk);
        #1;
        start_exe = 1'b1;
        md_op_exe = MUL_ITER ? OP_MULT : OP_DIV;
        srca_exe  = 32'd5;
        srcb_exe  = 32'd6;
        @(posedge clk);
        #1 start_exe = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        issue(OP_MTLO, 32'h0000_1234, 32'd0, 32'h0000_0000, 32'h0000_1234, 1'b0);

        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
